fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding and hazard unit for the 5-stage MIPS pipeline. It extends EX-stage
//  operand forwarding to NUM_SRC source ports and adds a multi-cycle MUL/DIV unit as a fourth source.
//  It issues ID-stage stalls for load-use hazards and multi-cycle RAW/WAW/structural hazards,
//  and tracks the in-flight MUL/DIV result with an internal scoreboard.
//  It sits beside the datapath: fwd_sel drives the EX operand muxes; stall freezes PC/IFID and
//  bubbles IDEX.
// PARAMETERS
//  REG_AW   5   register-address width
//  NUM_SRC  2   source operands per instruction (rs, rt, ...); source i uses slice [i*REG_AW +: REG_AW]
//  MD_LAT   4   MUL/DIV latency in cycles, from issue to result; legal range 3..15
//  CNT_W    16  width of the stall performance counter
// PORTS
//  clk            in   1               clock, rising edge
//  rst            in   1               asynchronous reset, active-high
//  ifid_src       in   NUM_SRC*REG_AW  source registers of the instruction in ID
//  ifid_src_used  in   NUM_SRC         bit i=1: ID instruction reads source i
//  ifid_rd        in   REG_AW          destination of the ID instruction
//  ifid_regwrite  in   1               ID instruction writes ifid_rd
//  ifid_is_md     in   1               ID instruction is a MUL/DIV
//  idex_src       in   NUM_SRC*REG_AW  source registers of the instruction in EX
//  idex_rd        in   REG_AW          destination of the EX instruction
//  idex_regwrite  in   1               EX instruction writes idex_rd
//  idex_memread   in   1               EX instruction is a load
//  exmem_rd       in   REG_AW          destination in MEM
//  exmem_regwrite in   1               MEM instruction writes exmem_rd
//  memwb_rd       in   REG_AW          destination in WB
//  memwb_regwrite in   1               WB instruction writes memwb_rd
//  md_issue       in   1               a MUL/DIV leaves EX this cycle
//  md_rd          in   REG_AW          destination of the issuing MUL/DIV
//  fwd_sel        out  NUM_SRC*2       per source: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 MUL/DIV result
//  stall          out  1               hold PC/IFID and insert a bubble into IDEX
//  md_busy        out  1               MUL/DIV result is pending
//  md_done        out  1               MUL/DIV result is valid; it is written to the regfile this cycle
//  md_wb_rd       out  REG_AW          destination of the pending MUL/DIV result
//  md_err         out  1               sticky flag: md_issue arrived while the unit was occupied
//  stall_cnt      out  CNT_W           saturating count of stall cycles
// BEHAVIOUR
//  State: md_cnt[3:0], md_rd_q, md_err_q, stall_cnt_q. All are cleared to 0 asynchronously on rst.
//    Reset mid-operation aborts the pending MUL/DIV; no md_done follows.
//  Scoreboard:
//    md_issue with md_cnt<=1: md_cnt<=MD_LAT and md_rd_q<=md_rd.
//      Issue in the md_done cycle (md_cnt==1) is legal and reloads the counter.
//    md_issue with md_cnt>=2: the issue is ignored and md_err_q<=1.
//    No issue: md_cnt decrements when non-zero.
//    md_busy=(md_cnt!=0); md_done=(md_cnt==1); md_wb_rd=md_rd_q.
//      Issue at cycle t gives md_busy in t+1..t+MD_LAT and md_done in t+MD_LAT.
//  Forwarding (combinational), per source s=idex_src[i]:
//    s==0 -> 00.
//    else exmem_regwrite && exmem_rd==s -> 10.
//    else memwb_regwrite && memwb_rd==s -> 01.
//    else md_done && md_rd_q==s -> 11.
//    else 00.
//    Priority is youngest-first; MD_LAT>=3 guarantees MEM/WB is younger than a completing MUL/DIV.
//  Stall (combinational) is the OR of:
//    load-use:    idex_memread && idex_regwrite && idex_rd!=0 && idex_rd matches any used ifid_src.
//    MD RAW:      md_cnt>=3 && md_rd_q!=0 && md_rd_q matches any used ifid_src.
//                 At md_cnt==2 the ID instruction proceeds and meets md_done in EX, taking path 11.
//    MD WAW:      md_cnt>=3 && ifid_regwrite && ifid_rd!=0 && ifid_rd==md_rd_q.
//    structural:  md_cnt>=2 && ifid_is_md.
//  stall_cnt_q increments on every cycle with stall=1 and saturates at all-ones.
//  During reset: registered outputs are 0; stall/fwd_sel follow the inputs with the MD terms inactive.
// STRUCTURE
//  cpu_pipe_pkg holds the FWD_RF/FWD_MEMWB/FWD_EXMEM/FWD_MD 2-bit encodings and REG_ZERO.
//  The sub-module md_scoreboard contains md_cnt, md_rd_q, md_err_q, md_busy, md_done and md_wb_rd.
//  The per-source forwarding and match logic is a generate loop over NUM_SRC.
// TESTING
//  1 EX/MEM vs MEM/WB: exmem_rd=memwb_rd=idex_src[0]=5, both regwrite -> fwd_sel[1:0]=10;
//    drop exmem_regwrite -> 01.
//  2 $zero: all rd=0, regwrite=1, idex_src=0 -> fwd_sel=0000; load to $0 -> stall=0.
//  3 load-use: idex_memread=1, idex_rd=7, ifid_src[1]=7, used=11 -> stall=1 and stall_cnt +1;
//    used=01 -> stall=0.
//  4 MD RAW: md_issue with md_rd=8 at t, ifid_src[0]=8 -> stall in t+1,t+2;
//    EX at t+4 gets fwd_sel=11 with md_done=1; stall_cnt=2.
//  5 structural/err: ifid_is_md at md_cnt=3 -> stall;
//    md_issue at md_cnt=2 -> ignored and md_err=1; issue at md_cnt=1 -> reload to MD_LAT, md_err stays 1.
//  6 rst asserted at md_cnt=2 -> md_busy/md_done/md_err/stall_cnt=0 immediately; no md_done after release.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline encodings for the forwarding/hazard unit and its scoreboard.
package cpu_pipe_pkg;
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10,
    FWD_MD    = 2'b11
  } fwd_sel_e;

  localparam int REG_ZERO = 0;
  localparam int MD_CNT_W = 4;
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding/hazard unit: stage register fields in, control out.
interface fwd_hazard_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC*REG_AW-1:0] ifid_src;
    logic [NUM_SRC-1:0]        ifid_src_used;
    logic [REG_AW-1:0]         ifid_rd;
    logic                      ifid_regwrite;
    logic                      ifid_is_md;
    logic [NUM_SRC*REG_AW-1:0] idex_src;
    logic [REG_AW-1:0]         idex_rd;
    logic                      idex_regwrite;
    logic                      idex_memread;
    logic [REG_AW-1:0]         exmem_rd;
    logic                      exmem_regwrite;
    logic [REG_AW-1:0]         memwb_rd;
    logic                      memwb_regwrite;
    logic                      md_issue;
    logic [REG_AW-1:0]         md_rd;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall;
    logic                      md_busy;
    logic                      md_done;
    logic [REG_AW-1:0]         md_wb_rd;
    logic                      md_err;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output ifid_src, ifid_src_used, ifid_rd, ifid_regwrite, ifid_is_md,
               idex_src, idex_rd, idex_regwrite, idex_memread,
               exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite, md_issue, md_rd,
        input  fwd_sel, stall, md_busy, md_done, md_wb_rd, md_err, stall_cnt
    );

    modport slave (
        input  ifid_src, ifid_src_used, ifid_rd, ifid_regwrite, ifid_is_md,
               idex_src, idex_rd, idex_regwrite, idex_memread,
               exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite, md_issue, md_rd,
        output fwd_sel, stall, md_busy, md_done, md_wb_rd, md_err, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit_md_scoreboard.sv
// Tracks the single in-flight MUL/DIV: countdown to writeback, its destination, and overlap errors.
module md_scoreboard
    import cpu_pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mdIssue,
    input  logic [REG_AW-1:0]   mdRd,
    output logic [MD_CNT_W-1:0] mdCnt,
    output logic                mdBusy,
    output logic                mdDone,
    output logic [REG_AW-1:0]   mdWbRd,
    output logic                mdErr
);
    logic [REG_AW-1:0] mdRdQ;
    logic              accept;

    // A new issue is accepted while idle or in the writeback cycle of the previous op.
    assign accept = mdIssue && (mdCnt <= MD_CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdCnt <= '0;
            mdRdQ <= '0;
            mdErr <= 1'b0;
        end else begin
            if (accept) begin
                mdCnt <= MD_CNT_W'(MD_LAT);
                mdRdQ <= mdRd;
            end else if (mdCnt != '0) begin
                mdCnt <= mdCnt - MD_CNT_W'(1);
            end
            if (mdIssue && !accept)
                mdErr <= 1'b1;
        end
    end

    assign mdBusy = (mdCnt != '0);
    assign mdDone = (mdCnt == MD_CNT_W'(1));
    assign mdWbRd = mdRdQ;
endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding over NUM_SRC sources plus ID-stage stall generation,
// including hazards against the multi-cycle MUL/DIV unit.
module fwd_hazard_unit
    import cpu_pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MD_LAT  = 4,
    parameter int CNT_W   = 16
) (
    input logic               clk,
    input logic               rst,
    fwd_hazard_unit_if.slave  hz
);
    localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

    logic [MD_CNT_W-1:0]          mdCnt;
    logic                         mdDone;
    logic [REG_AW-1:0]            mdWbRd;
    logic [NUM_SRC-1:0][1:0]      fwdSel;
    logic [NUM_SRC-1:0]           luHit, rawHit;
    logic                         mdGe2, mdGe3;
    logic                         stall;
    logic [CNT_W-1:0]             stallCntQ;

    md_scoreboard #(.REG_AW(REG_AW), .MD_LAT(MD_LAT)) u_md (
        .clk     (clk),
        .rst     (rst),
        .mdIssue (hz.md_issue),
        .mdRd    (hz.md_rd),
        .mdCnt   (mdCnt),
        .mdBusy  (hz.md_busy),
        .mdDone  (mdDone),
        .mdWbRd  (mdWbRd),
        .mdErr   (hz.md_err)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] exSrc, idSrc;
        fwd_sel_e          sel;

        assign exSrc = hz.idex_src[i*REG_AW +: REG_AW];
        assign idSrc = hz.ifid_src[i*REG_AW +: REG_AW];

        // Youngest producer wins; the MUL/DIV result is always older than MEM/WB.
        always_comb begin
            sel = FWD_RF;
            if (exSrc == RZ)                                     sel = FWD_RF;
            else if (hz.exmem_regwrite && hz.exmem_rd == exSrc)  sel = FWD_EXMEM;
            else if (hz.memwb_regwrite && hz.memwb_rd == exSrc)  sel = FWD_MEMWB;
            else if (mdDone && mdWbRd == exSrc)                  sel = FWD_MD;
        end

        assign fwdSel[i] = sel;
        assign luHit[i]  = hz.ifid_src_used[i] && (idSrc == hz.idex_rd);
        assign rawHit[i] = hz.ifid_src_used[i] && (idSrc == mdWbRd);
    end

    assign mdGe2 = (mdCnt >= MD_CNT_W'(2));
    // At count 2 a dependent instruction reaches EX exactly when the result is forwardable.
    assign mdGe3 = (mdCnt >= MD_CNT_W'(3));

    assign stall = (hz.idex_memread && hz.idex_regwrite && hz.idex_rd != RZ && |luHit)
                 || (mdGe3 && mdWbRd != RZ && |rawHit)
                 || (mdGe3 && hz.ifid_regwrite && hz.ifid_rd != RZ && hz.ifid_rd == mdWbRd)
                 || (mdGe2 && hz.ifid_is_md);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stallCntQ <= '0;
        else if (stall && !(&stallCntQ))
            stallCntQ <= stallCntQ + CNT_W'(1);
    end

    assign hz.fwd_sel   = fwdSel;
    assign hz.stall     = stall;
    assign hz.md_done   = mdDone;
    assign hz.md_wb_rd  = mdWbRd;
    assign hz.stall_cnt = stallCntQ;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized + directed bench; a timeline model of the MUL/DIV unit feeds scoreboard queues.
module tb_fwd_hazard_unit;
    localparam int REG_AW = 5, NUM_SRC = 2, MD_LAT = 4, CNT_W = 16;

    typedef struct {
        logic [NUM_SRC*REG_AW-1:0] ifidSrc;
        logic [NUM_SRC-1:0]        used;
        logic [REG_AW-1:0]         ifidRd;
        logic                      ifidRw, ifidMd;
        logic [NUM_SRC*REG_AW-1:0] idexSrc;
        logic [REG_AW-1:0]         idexRd;
        logic                      idexRw, idexMr;
        logic [REG_AW-1:0]         exmemRd, memwbRd;
        logic                      exmemRw, memwbRw;
        logic                      mdIssue;
        logic [REG_AW-1:0]         mdRd;
        logic                      rst;
    } stim_t;

    typedef struct {
        logic [NUM_SRC*2-1:0] fwd;
        logic                 stall, busy, done, err;
        logic [REG_AW-1:0]    wbRd;
        logic [CNT_W-1:0]     cnt;
        int                   cyc;
    } exp_t;

    typedef struct {
        logic [REG_AW-1:0] rd;
        int                at;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) hz ();

    fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    exp_t  expQ[$];
    done_t doneQ[$];
    int    tests = 0, fails = 0;
    int    cyc = 0;

    // Model state: completion cycle of the pending op (-1 none), its rd, sticky err, stall total.
    int                doneAt = -1;
    logic [REG_AW-1:0] mdRdM = '0;
    logic              errM = 1'b0;
    int                stallM = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want, input int c);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, want);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.ifidSrc = '0;
        s.idexSrc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s.ifidSrc[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
            s.idexSrc[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
        end
        s.used    = NUM_SRC'($urandom);
        s.ifidRd  = REG_AW'($urandom_range(0, 7));
        s.ifidRw  = 1'($urandom);
        s.ifidMd  = ($urandom_range(0, 3) == 0);
        s.idexRd  = REG_AW'($urandom_range(0, 7));
        s.idexRw  = 1'($urandom);
        s.idexMr  = ($urandom_range(0, 3) == 0);
        s.exmemRd = REG_AW'($urandom_range(0, 7));
        s.exmemRw = 1'($urandom);
        s.memwbRd = REG_AW'($urandom_range(0, 7));
        s.memwbRw = 1'($urandom);
        s.mdIssue = ($urandom_range(0, 3) == 0);
        s.mdRd    = REG_AW'($urandom_range(0, 7));
        s.rst     = ($urandom_range(0, 63) == 0);
        return s;
    endfunction

    task automatic cycle(input stim_t s);
        exp_t        e;
        int          r;
        logic [REG_AW-1:0] src;
        logic [1:0]  f;
        logic        lu, raw;
        @(posedge clk);
        cyc++;
        #1;
        rst               = s.rst;
        hz.ifid_src       = s.ifidSrc;
        hz.ifid_src_used  = s.used;
        hz.ifid_rd        = s.ifidRd;
        hz.ifid_regwrite  = s.ifidRw;
        hz.ifid_is_md     = s.ifidMd;
        hz.idex_src       = s.idexSrc;
        hz.idex_rd        = s.idexRd;
        hz.idex_regwrite  = s.idexRw;
        hz.idex_memread   = s.idexMr;
        hz.exmem_rd       = s.exmemRd;
        hz.exmem_regwrite = s.exmemRw;
        hz.memwb_rd       = s.memwbRd;
        hz.memwb_regwrite = s.memwbRw;
        hz.md_issue       = s.mdIssue;
        hz.md_rd          = s.mdRd;
        #1;
        if (s.rst) begin
            doneAt = -1; mdRdM = '0; errM = 1'b0; stallM = 0;
            doneQ.delete();
        end
        // Cycles remaining until (and including) the writeback cycle.
        r = (doneAt >= cyc) ? doneAt - cyc + 1 : 0;
        e.fwd = '0;
        lu = 1'b0; raw = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src = s.idexSrc[i*REG_AW +: REG_AW];
            f = 2'b00;
            if (src != 0) begin
                if (s.exmemRw && s.exmemRd == src)      f = 2'b10;
                else if (s.memwbRw && s.memwbRd == src) f = 2'b01;
                else if (r == 1 && mdRdM == src)        f = 2'b11;
            end
            e.fwd[i*2 +: 2] = f;
            src = s.ifidSrc[i*REG_AW +: REG_AW];
            if (s.used[i] && src == s.idexRd) lu = 1'b1;
            if (s.used[i] && src == mdRdM)    raw = 1'b1;
        end
        e.stall = (s.idexMr && s.idexRw && s.idexRd != 0 && lu)
               || (r >= 3 && mdRdM != 0 && raw)
               || (r >= 3 && s.ifidRw && s.ifidRd != 0 && s.ifidRd == mdRdM)
               || (r >= 2 && s.ifidMd);
        e.busy = (r != 0);
        e.done = (r == 1);
        e.err  = errM;
        e.wbRd = mdRdM;
        e.cnt  = CNT_W'(stallM);
        e.cyc  = cyc;
        expQ.push_back(e);
        if (!s.rst) begin
            if (e.stall && stallM < (1 << CNT_W) - 1) stallM++;
            if (s.mdIssue) begin
                if (r <= 1) begin
                    doneAt = cyc + MD_LAT;
                    mdRdM  = s.mdRd;
                    doneQ.push_back('{rd: s.mdRd, at: doneAt});
                end else begin
                    errM = 1'b1;
                end
            end
        end
    endtask

    // Monitor: every cycle presents combinational results; md_done marks a writeback event.
    always @(negedge clk) begin
        exp_t  e;
        done_t d;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            chk("fwd_sel",   32'(hz.fwd_sel),   32'(e.fwd),   e.cyc);
            chk("stall",     32'(hz.stall),     32'(e.stall), e.cyc);
            chk("md_busy",   32'(hz.md_busy),   32'(e.busy),  e.cyc);
            chk("md_done",   32'(hz.md_done),   32'(e.done),  e.cyc);
            chk("md_err",    32'(hz.md_err),    32'(e.err),   e.cyc);
            chk("md_wb_rd",  32'(hz.md_wb_rd),  32'(e.wbRd),  e.cyc);
            chk("stall_cnt", 32'(hz.stall_cnt), 32'(e.cnt),   e.cyc);
        end
        if (hz.md_done === 1'b1) begin
            if (doneQ.size() == 0) begin
                chk("md_done_unexpected", 32'(1), 32'(0), cyc);
            end else begin
                d = doneQ.pop_front();
                chk("md_done_rd",  32'(hz.md_wb_rd), 32'(d.rd), cyc);
                chk("md_done_cyc", 32'(cyc),         32'(d.at), cyc);
            end
        end
    end

    initial begin
        stim_t s;
        hz.ifid_src = '0; hz.ifid_src_used = '0; hz.ifid_rd = '0; hz.ifid_regwrite = 1'b0;
        hz.ifid_is_md = 1'b0; hz.idex_src = '0; hz.idex_rd = '0; hz.idex_regwrite = 1'b0;
        hz.idex_memread = 1'b0; hz.exmem_rd = '0; hz.exmem_regwrite = 1'b0; hz.memwb_rd = '0;
        hz.memwb_regwrite = 1'b0; hz.md_issue = 1'b0; hz.md_rd = '0;

        s = idle(); s.rst = 1'b1;
        cycle(s); cycle(s);
        cycle(idle());

        // EX/MEM beats MEM/WB, then MEM/WB alone
        s = idle(); s.idexSrc[4:0] = 5'd5; s.exmemRd = 5'd5; s.memwbRd = 5'd5;
        s.exmemRw = 1'b1; s.memwbRw = 1'b1;
        cycle(s);
        s.exmemRw = 1'b0;
        cycle(s);

        // $zero never forwards nor stalls on a load
        s = idle(); s.exmemRw = 1'b1; s.memwbRw = 1'b1; s.idexRw = 1'b1; s.idexMr = 1'b1;
        s.used = 2'b11;
        cycle(s);

        // load-use on source 1, then source 1 unused
        s = idle(); s.idexMr = 1'b1; s.idexRw = 1'b1; s.idexRd = 5'd7;
        s.ifidSrc[9:5] = 5'd7; s.used = 2'b11;
        cycle(s);
        s.used = 2'b01;
        cycle(s);

        // MD RAW: stall while count >= 3, then forward from MUL/DIV in the done cycle
        s = idle(); s.mdIssue = 1'b1; s.mdRd = 5'd8;
        cycle(s);
        s = idle(); s.ifidSrc[4:0] = 5'd8; s.used = 2'b01;
        cycle(s); cycle(s); cycle(s);
        s = idle(); s.idexSrc[4:0] = 5'd8;
        cycle(s);
        cycle(idle());

        // structural stall, ignored overlapping issue, legal reload in the done cycle
        s = idle(); s.mdIssue = 1'b1; s.mdRd = 5'd3;
        cycle(s);
        cycle(idle());
        s = idle(); s.ifidMd = 1'b1;
        cycle(s);
        s = idle(); s.mdIssue = 1'b1; s.mdRd = 5'd4;
        cycle(s);
        s.mdRd = 5'd6;
        cycle(s);
        for (int i = 0; i < MD_LAT + 1; i++) cycle(idle());

        // reset in the middle of an operation aborts it
        s = idle(); s.mdIssue = 1'b1; s.mdRd = 5'd2;
        cycle(s);
        cycle(idle()); cycle(idle());
        s = idle(); s.rst = 1'b1;
        cycle(s);
        for (int i = 0; i < MD_LAT + 2; i++) cycle(idle());

        for (int n = 0; n < 600; n++) cycle(rnd());
        for (int i = 0; i < MD_LAT + 2; i++) cycle(idle());

        @(negedge clk);
        #1;
        chk("exp_queue_drained",  32'(expQ.size()),  32'(0), cyc);
        chk("done_queue_drained", 32'(doneQ.size()), 32'(0), cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end
endmodule
